// File: rtl/act_window_reader_pkg.sv
// Shared definitions for the window-reader family (activation and weight
// readers): default widths and the common control FSM state encoding.
package act_window_reader_pkg;

  // Width of every index and command field (entry, y, x, K, ky, kx).
  localparam int PKG_IDX_W = 16;

  // Default activation/weight word width in bits.
  localparam int PKG_DATA_SIZE = 64;

  // Control FSM shared by the window readers.
  //   IDLE  : waiting for a command
  //   RUN   : scanning the window, one capture per advance
  //   DRAIN : final word captured, waiting for it to be accepted
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_e;

endpackage : act_window_reader_pkg

// File: rtl/act_window_reader_if.sv
// Output word stream of the window reader: valid/ready handshake plus the
// window word, its (ky,kx) offset inside the window and an end-of-window flag.
interface act_window_reader_if #(
  parameter int DATA_SIZE = act_window_reader_pkg::PKG_DATA_SIZE,
  parameter int IDX_W     = act_window_reader_pkg::PKG_IDX_W
);

  logic                 out_valid;
  logic                 out_ready;
  logic [DATA_SIZE-1:0] out_data;
  logic [IDX_W-1:0]     out_ky;
  logic [IDX_W-1:0]     out_kx;
  logic                 out_last;

  // Producer side: the window reader.
  modport master (
    output out_valid,
    output out_data,
    output out_ky,
    output out_kx,
    output out_last,
    input  out_ready
  );

  // Consumer side: whatever accepts the window words.
  modport slave (
    input  out_valid,
    input  out_data,
    input  out_ky,
    input  out_kx,
    input  out_last,
    output out_ready
  );

endinterface : act_window_reader_if

// File: rtl/act_window_reader_window_counter.sv
// Row-major (ky,kx) position counter for a KxK window.
// kx runs 0..K-1 and wraps to 0 while ky increments. last flags the final
// position (K-1,K-1). clear has priority over step.
module window_counter #(
  parameter int IDX_W = act_window_reader_pkg::PKG_IDX_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             step,
  input  logic             clear,
  input  logic [IDX_W-1:0] k,
  output logic [IDX_W-1:0] ky,
  output logic [IDX_W-1:0] kx,
  output logic             last
);

  localparam logic [IDX_W-1:0] ONE = {{(IDX_W-1){1'b0}}, 1'b1};

  logic [IDX_W-1:0] ky_q, ky_d;
  logic [IDX_W-1:0] kx_q, kx_d;
  logic [IDX_W-1:0] k_m1;
  logic             kx_end;

  assign k_m1   = k - ONE;
  assign kx_end = (kx_q == k_m1);

  // Next position: restart on clear, otherwise row-major step.
  always_comb begin
    ky_d = ky_q;
    kx_d = kx_q;
    if (clear) begin
      ky_d = '0;
      kx_d = '0;
    end else if (step) begin
      if (kx_end) begin
        kx_d = '0;
        ky_d = ky_q + ONE;
      end else begin
        kx_d = kx_q + ONE;
      end
    end
  end

  // Position register, cleared asynchronously by reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ky_q <= '0;
      kx_q <= '0;
    end else begin
      ky_q <= ky_d;
      kx_q <= kx_d;
    end
  end

  assign ky   = ky_q;
  assign kx   = kx_q;
  assign last = kx_end && (ky_q == k_m1);

endmodule : window_counter

// File: rtl/act_window_reader.sv
// Activation window reader: given (entry, y, x, K), walks the KxK window
// row-major, drives the read indices to an external combinational activation
// memory and streams each returned word out through one output register
// stage with valid/ready backpressure.
module act_window_reader #(
  parameter int DATA_SIZE = act_window_reader_pkg::PKG_DATA_SIZE,
  parameter int IDX_W     = act_window_reader_pkg::PKG_IDX_W
) (
  input  logic                 clk,
  input  logic                 rst_n,
  // Command
  input  logic                 start,
  input  logic [IDX_W-1:0]     cmd_entry,
  input  logic [IDX_W-1:0]     cmd_y,
  input  logic [IDX_W-1:0]     cmd_x,
  input  logic [IDX_W-1:0]     cmd_k,
  // Activation memory read port
  output logic [IDX_W-1:0]     rd_entry,
  output logic [IDX_W-1:0]     rd_y,
  output logic [IDX_W-1:0]     rd_x,
  input  logic [DATA_SIZE-1:0] rd_data,
  // Output word stream
  act_window_reader_if.master  out_if,
  // Status
  output logic                 busy,
  output logic                 done
);

  import act_window_reader_pkg::*;

  state_e               state_q, state_d;

  // Latched command
  logic [IDX_W-1:0]     entry_q, entry_d;
  logic [IDX_W-1:0]     y_q, y_d;
  logic [IDX_W-1:0]     x_q, x_d;
  logic [IDX_W-1:0]     k_q, k_d;

  // Output register stage
  logic                 out_valid_q, out_valid_d;
  logic                 out_last_q, out_last_d;
  logic [DATA_SIZE-1:0] out_data_q, out_data_d;
  logic [IDX_W-1:0]     out_ky_q, out_ky_d;
  logic [IDX_W-1:0]     out_kx_q, out_kx_d;
  logic                 done_q, done_d;

  // Window position
  logic                 cnt_step;
  logic                 cnt_clear;
  logic [IDX_W-1:0]     cnt_ky;
  logic [IDX_W-1:0]     cnt_kx;
  logic                 cnt_last;

  logic                 advance;
  logic                 xfer;

  window_counter #(
    .IDX_W (IDX_W)
  ) u_window_counter (
    .clk   (clk),
    .rst_n (rst_n),
    .step  (cnt_step),
    .clear (cnt_clear),
    .k     (k_q),
    .ky    (cnt_ky),
    .kx    (cnt_kx),
    .last  (cnt_last)
  );

  // A new word may be captured whenever the output slot is empty or is
  // being emptied this cycle; a transfer is the consumer taking the word.
  assign advance = (state_q == RUN) && (!out_valid_q || out_if.out_ready);
  assign xfer    = out_valid_q && out_if.out_ready;

  // Read indices wrap modulo 2^IDX_W; the memory is never bounds-checked.
  assign rd_entry = entry_q;
  assign rd_y     = y_q + cnt_ky;
  assign rd_x     = x_q + cnt_kx;

  // FSM next-state, command latch and output-stage update.
  always_comb begin
    state_d     = state_q;
    entry_d     = entry_q;
    y_d         = y_q;
    x_d         = x_q;
    k_d         = k_q;
    out_valid_d = out_valid_q;
    out_last_d  = out_last_q;
    out_data_d  = out_data_q;
    out_ky_d    = out_ky_q;
    out_kx_d    = out_kx_q;
    done_d      = 1'b0;
    cnt_step    = 1'b0;
    cnt_clear   = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (start) begin
          if (cmd_k != '0) begin
            entry_d   = cmd_entry;
            y_d       = cmd_y;
            x_d       = cmd_x;
            k_d       = cmd_k;
            cnt_clear = 1'b1;
            state_d   = RUN;
          end else begin
            // Empty window: report completion without producing a word.
            done_d = 1'b1;
          end
        end
      end

      RUN: begin
        if (advance) begin
          out_data_d  = rd_data;
          out_ky_d    = cnt_ky;
          out_kx_d    = cnt_kx;
          out_last_d  = cnt_last;
          out_valid_d = 1'b1;
          cnt_step    = 1'b1;
          if (cnt_last) begin
            state_d = DRAIN;
          end
        end else if (xfer) begin
          out_valid_d = 1'b0;
        end
      end

      DRAIN: begin
        if (xfer) begin
          out_valid_d = 1'b0;
          out_last_d  = 1'b0;
          done_d      = 1'b1;
          state_d     = IDLE;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State, command and output registers; reset abandons any window.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      entry_q     <= '0;
      y_q         <= '0;
      x_q         <= '0;
      k_q         <= '0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      out_data_q  <= '0;
      out_ky_q    <= '0;
      out_kx_q    <= '0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      entry_q     <= entry_d;
      y_q         <= y_d;
      x_q         <= x_d;
      k_q         <= k_d;
      out_valid_q <= out_valid_d;
      out_last_q  <= out_last_d;
      out_data_q  <= out_data_d;
      out_ky_q    <= out_ky_d;
      out_kx_q    <= out_kx_d;
      done_q      <= done_d;
    end
  end

  assign out_if.out_valid = out_valid_q;
  assign out_if.out_last  = out_last_q;
  assign out_if.out_data  = out_data_q;
  assign out_if.out_ky    = out_ky_q;
  assign out_if.out_kx    = out_kx_q;

  assign busy = (state_q != IDLE);
  assign done = done_q;

endmodule : act_window_reader

// File: tb/tb_act_window_reader.sv
// Directed bench for act_window_reader with a combinational activation
// memory whose words encode the address they were read from.
module tb_act_window_reader;

  localparam int DW = 64;
  localparam int IW = 16;

  logic          clk;
  logic          rst_n;
  logic          start;
  logic [IW-1:0] cmd_entry, cmd_y, cmd_x, cmd_k;
  logic [IW-1:0] rd_entry, rd_y, rd_x;
  logic [DW-1:0] rd_data;
  logic          busy, done;

  int n_tests = 0;
  int n_fail  = 0;

  act_window_reader_if #(.DATA_SIZE(DW), .IDX_W(IW)) ob ();

  act_window_reader #(.DATA_SIZE(DW), .IDX_W(IW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .cmd_entry (cmd_entry),
    .cmd_y     (cmd_y),
    .cmd_x     (cmd_x),
    .cmd_k     (cmd_k),
    .rd_entry  (rd_entry),
    .rd_y      (rd_y),
    .rd_x      (rd_x),
    .rd_data   (rd_data),
    .out_if    (ob),
    .busy      (busy),
    .done      (done)
  );

  function automatic logic [DW-1:0] mem_word(input logic [IW-1:0] e,
                                             input logic [IW-1:0] y,
                                             input logic [IW-1:0] x);
    return {e, y, x, 16'hC3A5};
  endfunction

  assign rd_data = mem_word(rd_entry, rd_y, rd_x);

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, tests=%0d", n_tests);
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic issue(input logic [IW-1:0] e, input logic [IW-1:0] y,
                       input logic [IW-1:0] x, input logic [IW-1:0] k);
    @(negedge clk);
    cmd_entry = e;
    cmd_y     = y;
    cmd_x     = x;
    cmd_k     = k;
    start     = 1'b1;
    @(negedge clk);
    start     = 1'b0;
  endtask

  task automatic expect_word(input string tag, input logic [IW-1:0] e,
                             input logic [IW-1:0] y, input logic [IW-1:0] x,
                             input logic [IW-1:0] ky, input logic [IW-1:0] kx,
                             input logic last);
    @(negedge clk);
    chk({tag, ".valid"}, DW'(ob.out_valid), DW'(1'b1));
    chk({tag, ".data"},  ob.out_data,       mem_word(e, y, x));
    chk({tag, ".ky"},    DW'(ob.out_ky),    DW'(ky));
    chk({tag, ".kx"},    DW'(ob.out_kx),    DW'(kx));
    chk({tag, ".last"},  DW'(ob.out_last),  DW'(last));
  endtask

  initial begin
    logic [3:0]    pat;
    int            n;
    logic          stalled;
    logic [DW-1:0] snap_data;
    logic [DW-1:0] snap_ctl;
    logic [IW-1:0] eky, ekx;

    rst_n = 1'b0; start = 1'b0;
    cmd_entry = '0; cmd_y = '0; cmd_x = '0; cmd_k = '0;
    ob.out_ready = 1'b1;

    // Reset state
    @(negedge clk);
    @(negedge clk);
    chk("rst.valid", DW'(ob.out_valid), '0);
    chk("rst.last",  DW'(ob.out_last),  '0);
    chk("rst.data",  ob.out_data,       '0);
    chk("rst.ky",    DW'(ob.out_ky),    '0);
    chk("rst.kx",    DW'(ob.out_kx),    '0);
    chk("rst.busy",  DW'(busy),         '0);
    chk("rst.done",  DW'(done),         '0);
    chk("rst.rd",    DW'({rd_entry, rd_y, rd_x}), '0);
    rst_n = 1'b1;

    // K=2 at (3,5), consumer always ready
    issue(16'd7, 16'd3, 16'd5, 16'd2);
    chk("k2.busy0",  DW'(busy),         DW'(1'b1));
    chk("k2.valid0", DW'(ob.out_valid), '0);
    chk("k2.rd0",    DW'({rd_entry, rd_y, rd_x}), DW'({16'd7, 16'd3, 16'd5}));
    expect_word("k2.w0", 16'd7, 16'd3, 16'd5, 16'd0, 16'd0, 1'b0);
    expect_word("k2.w1", 16'd7, 16'd3, 16'd6, 16'd0, 16'd1, 1'b0);
    expect_word("k2.w2", 16'd7, 16'd4, 16'd5, 16'd1, 16'd0, 1'b0);
    expect_word("k2.w3", 16'd7, 16'd4, 16'd6, 16'd1, 16'd1, 1'b1);
    chk("k2.done_early", DW'(done), '0);
    @(negedge clk);
    chk("k2.done",   DW'(done),         DW'(1'b1));
    chk("k2.vend",   DW'(ob.out_valid), '0);
    chk("k2.lend",   DW'(ob.out_last),  '0);
    chk("k2.idle",   DW'(busy),         '0);
    @(negedge clk);
    chk("k2.done_pulse", DW'(done),     '0);

    // Row wrap of the y index
    issue(16'd1, 16'hFFFF, 16'h0010, 16'd2);
    expect_word("wrap.w0", 16'd1, 16'hFFFF, 16'h0010, 16'd0, 16'd0, 1'b0);
    expect_word("wrap.w1", 16'd1, 16'hFFFF, 16'h0011, 16'd0, 16'd1, 1'b0);
    chk("wrap.rd_y", DW'(rd_y), DW'(16'h0000));
    expect_word("wrap.w2", 16'd1, 16'h0000, 16'h0010, 16'd1, 16'd0, 1'b0);
    expect_word("wrap.w3", 16'd1, 16'h0000, 16'h0011, 16'd1, 16'd1, 1'b1);
    @(negedge clk);
    chk("wrap.done", DW'(done), DW'(1'b1));

    // Empty window
    issue(16'd9, 16'd1, 16'd1, 16'd0);
    chk("k0.done",  DW'(done),         DW'(1'b1));
    chk("k0.busy",  DW'(busy),         '0);
    chk("k0.valid", DW'(ob.out_valid), '0);
    @(negedge clk);
    chk("k0.done_pulse", DW'(done),    '0);
    chk("k0.busy2",  DW'(busy),        '0);
    chk("k0.valid2", DW'(ob.out_valid), '0);

    // K=3 with ready pattern 1,0,0,1 repeating
    issue(16'd2, 16'd10, 16'd20, 16'd3);
    pat = 4'b1001;
    n = 0;
    stalled = 1'b0;
    snap_data = '0;
    snap_ctl = '0;
    for (int c = 0; c < 100 && n < 9; c++) begin
      @(negedge clk);
      ob.out_ready = pat[c % 4];
      if (stalled) begin
        chk("bp.stall_data", ob.out_data, snap_data);
        chk("bp.stall_ctl",  DW'({ob.out_valid, ob.out_last, ob.out_ky, ob.out_kx}), snap_ctl);
      end
      if (ob.out_valid && ob.out_ready) begin
        eky = IW'(n / 3);
        ekx = IW'(n % 3);
        chk("bp.data", ob.out_data, mem_word(16'd2, 16'd10 + eky, 16'd20 + ekx));
        chk("bp.pos",  DW'({ob.out_ky, ob.out_kx}), DW'({eky, ekx}));
        chk("bp.last", DW'(ob.out_last), DW'(n == 8));
        n++;
      end
      stalled   = ob.out_valid && !ob.out_ready;
      snap_data = ob.out_data;
      snap_ctl  = DW'({ob.out_valid, ob.out_last, ob.out_ky, ob.out_kx});
    end
    chk("bp.count", DW'(n), DW'(9));
    @(negedge clk);
    ob.out_ready = 1'b1;
    chk("bp.done",  DW'(done),         DW'(1'b1));
    chk("bp.valid", DW'(ob.out_valid), '0);

    // start reasserted with other fields while busy
    issue(16'd3, 16'd1, 16'd1, 16'd2);
    cmd_entry = 16'd9; cmd_y = 16'd9; cmd_x = 16'd9; cmd_k = 16'd5;
    start = 1'b1;
    expect_word("ign.w0", 16'd3, 16'd1, 16'd1, 16'd0, 16'd0, 1'b0);
    start = 1'b0;
    chk("ign.rd_entry", DW'(rd_entry), DW'(16'd3));
    expect_word("ign.w1", 16'd3, 16'd1, 16'd2, 16'd0, 16'd1, 1'b0);
    expect_word("ign.w2", 16'd3, 16'd2, 16'd1, 16'd1, 16'd0, 1'b0);
    expect_word("ign.w3", 16'd3, 16'd2, 16'd2, 16'd1, 16'd1, 1'b1);
    @(negedge clk);
    chk("ign.done", DW'(done), DW'(1'b1));
    @(negedge clk);

    // Reset in the middle of a window
    issue(16'd4, 16'd2, 16'd2, 16'd2);
    expect_word("mid.w0", 16'd4, 16'd2, 16'd2, 16'd0, 16'd0, 1'b0);
    expect_word("mid.w1", 16'd4, 16'd2, 16'd3, 16'd0, 16'd1, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    chk("mid.valid", DW'(ob.out_valid), '0);
    chk("mid.data",  ob.out_data,       '0);
    chk("mid.pos",   DW'({ob.out_ky, ob.out_kx, ob.out_last}), '0);
    chk("mid.busy",  DW'(busy),         '0);
    chk("mid.done",  DW'(done),         '0);
    chk("mid.rd",    DW'({rd_entry, rd_y, rd_x}), '0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("mid.no_done", DW'(done),       '0);
    chk("mid.idle",    DW'(ob.out_valid), '0);
    issue(16'd5, 16'd6, 16'd7, 16'd1);
    chk("k1.busy", DW'(busy), DW'(1'b1));
    expect_word("k1.w0", 16'd5, 16'd6, 16'd7, 16'd0, 16'd0, 1'b1);
    @(negedge clk);
    chk("k1.done",  DW'(done),         DW'(1'b1));
    chk("k1.valid", DW'(ob.out_valid), '0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule : tb_act_window_reader
